// File: rtl/apb_pkg.sv
// Shared types for the APB requester: FSM state encoding and the response record.
package apb_pkg;

    localparam int RSP_DATA_MAX = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_e;

    typedef struct packed {
        logic [RSP_DATA_MAX-1:0] rdata;
        logic                    err;
        logic                    timeout;
    } apb_rsp_t;

    // Bit width needed to index n items, never below one bit.
    function automatic int width_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/apb_timeout_counter.sv
// Saturating ACCESS-cycle counter; flags the cycle in which the limit is reached.
module apb_timeout_counter #(
    parameter int CNT_WIDTH = 1
) (
    input  logic                 pclk,
    input  logic                 presetn,
    input  logic                 enable,
    input  logic                 clear,
    input  logic [CNT_WIDTH-1:0] limit,
    output logic                 expired
);

    logic [CNT_WIDTH-1:0] count_r;

    // Count elapsed ACCESS cycles, holding at all-ones instead of wrapping.
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            count_r <= '0;
        end else if (clear) begin
            count_r <= '0;
        end else if (enable && (count_r != {CNT_WIDTH{1'b1}})) begin
            count_r <= count_r + CNT_WIDTH'(1);
        end else begin
            count_r <= count_r;
        end
    end

    // count_r is zero during the first ACCESS cycle, so the current cycle number is count_r+1.
    always_comb begin
        expired = 1'b0;
        if (enable && (limit != '0)) begin
            expired = (({1'b0, count_r} + (CNT_WIDTH + 1)'(1)) >= {1'b0, limit});
        end else begin
            expired = 1'b0;
        end
    end

endmodule

// File: rtl/apb_requester.sv
// APB requester (APB2..APB5): turns one request handshake into one APB transfer
// and returns the outcome on a valid/ready response channel.
module apb_requester
    import apb_pkg::*;
#(
    parameter int VERSION            = 2,
    parameter int PSEL_WIDTH         = 1,
    parameter int ADDR_WIDTH         = 32,
    parameter int DATA_WIDTH         = 32,
    parameter int Pstrb_Support      = 0,
    parameter int Protection_Support = 0,
    parameter int TIMEOUT_CYCLES     = 0
) (
    input  logic                                           pclk,
    input  logic                                           presetn,
    input  logic                                           req_valid,
    output logic                                           req_ready,
    input  logic                                           req_write,
    input  logic [ADDR_WIDTH-1:0]                          req_addr,
    input  logic [DATA_WIDTH-1:0]                          req_wdata,
    input  logic [DATA_WIDTH/8-1:0]                        req_strb,
    input  logic [2:0]                                     req_prot,
    input  logic [((PSEL_WIDTH > 1) ? $clog2(PSEL_WIDTH) : 1)-1:0] req_sel,
    output logic                                           rsp_valid,
    input  logic                                           rsp_ready,
    output logic [DATA_WIDTH-1:0]                          rsp_rdata,
    output logic                                           rsp_err,
    output logic                                           rsp_timeout,
    output logic [ADDR_WIDTH-1:0]                          paddr,
    output logic [PSEL_WIDTH-1:0]                          psel,
    output logic                                           penable,
    output logic                                           pwrite,
    output logic [DATA_WIDTH-1:0]                          pwdata,
    output logic [DATA_WIDTH/8-1:0]                        pstrb,
    output logic [2:0]                                     pprot,
    input  logic                                           pready,
    input  logic [DATA_WIDTH-1:0]                          prdata,
    input  logic                                           pslverr
);

    localparam int CNT_WIDTH = width_min1(TIMEOUT_CYCLES + 1);
    localparam bit STRB_EN   = (Pstrb_Support != 0) && (VERSION >= 4);
    localparam bit PROT_EN   = (Protection_Support != 0) && (VERSION >= 4);
    localparam bit WAIT_EN   = (VERSION >= 3);

    apb_state_e              state_r, state_s;
    apb_rsp_t                rsp_r, rsp_s;
    logic                    req_ready_s, rsp_valid_s, penable_s, pwrite_s;
    logic [PSEL_WIDTH-1:0]   psel_s, sel_dec_s;
    logic [ADDR_WIDTH-1:0]   paddr_s;
    logic [DATA_WIDTH-1:0]   pwdata_s;
    logic [DATA_WIDTH/8-1:0] pstrb_s;
    logic [2:0]              pprot_s;
    logic                    pready_eff_s, pslverr_eff_s, expired_s;

    assign pready_eff_s  = WAIT_EN ? pready  : 1'b1;
    assign pslverr_eff_s = WAIT_EN ? pslverr : 1'b0;
    assign rsp_rdata     = rsp_r.rdata[DATA_WIDTH-1:0];
    assign rsp_err       = rsp_r.err;
    assign rsp_timeout   = rsp_r.timeout;

    apb_timeout_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_timeout (
        .pclk    (pclk),
        .presetn (presetn),
        .enable  (state_r == ST_ACCESS),
        .clear   (state_r != ST_ACCESS),
        .limit   (CNT_WIDTH'(TIMEOUT_CYCLES)),
        .expired (expired_s)
    );

    // One-hot completer decode; an out-of-range index yields all zeros.
    always_comb begin
        sel_dec_s = '0;
        for (int i = 0; i < PSEL_WIDTH; i++) begin
            if (32'(req_sel) == i) begin
                sel_dec_s[i] = 1'b1;
            end else begin
                sel_dec_s[i] = 1'b0;
            end
        end
    end

    // Next-state and next-output logic; the APB output registers themselves hold the captured request.
    always_comb begin
        state_s     = state_r;
        req_ready_s = 1'b0;
        rsp_valid_s = rsp_valid;
        rsp_s       = rsp_r;
        psel_s      = psel;
        penable_s   = penable;
        paddr_s     = paddr;
        pwrite_s    = pwrite;
        pwdata_s    = pwdata;
        pstrb_s     = pstrb;
        pprot_s     = pprot;
        case (state_r)
            ST_IDLE: begin
                req_ready_s = 1'b1;
                if (req_valid && req_ready) begin
                    state_s     = ST_SETUP;
                    req_ready_s = 1'b0;
                    psel_s      = sel_dec_s;
                    if (|sel_dec_s) begin
                        paddr_s  = req_addr;
                        pwrite_s = req_write;
                        pwdata_s = req_wdata;
                        pstrb_s  = (STRB_EN && req_write) ? req_strb : '0;
                        pprot_s  = PROT_EN ? req_prot : 3'b000;
                    end else begin
                        paddr_s  = '0;
                        pwrite_s = 1'b0;
                        pwdata_s = '0;
                        pstrb_s  = '0;
                        pprot_s  = 3'b000;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                state_s   = ST_ACCESS;
                penable_s = |psel;
            end
            ST_ACCESS: begin
                // pready is tested before the timeout so a same-cycle pready wins.
                if (!(|psel) || pready_eff_s || expired_s) begin
                    state_s     = ST_RESP;
                    rsp_valid_s = 1'b1;
                    psel_s      = '0;
                    penable_s   = 1'b0;
                    paddr_s     = '0;
                    pwrite_s    = 1'b0;
                    pwdata_s    = '0;
                    pstrb_s     = '0;
                    pprot_s     = 3'b000;
                    if (!(|psel)) begin
                        rsp_s = '{rdata: '0, err: 1'b1, timeout: 1'b0};
                    end else if (pready_eff_s) begin
                        rsp_s.err     = pslverr_eff_s;
                        rsp_s.timeout = 1'b0;
                        if (pwrite) begin
                            rsp_s.rdata = '0;
                        end else begin
                            rsp_s.rdata = RSP_DATA_MAX'(prdata);
                        end
                    end else begin
                        rsp_s = '{rdata: '0, err: 1'b1, timeout: 1'b1};
                    end
                end else begin
                    state_s = ST_ACCESS;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_s     = ST_IDLE;
                    rsp_valid_s = 1'b0;
                    req_ready_s = 1'b1;
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: begin
                state_s     = ST_IDLE;
                rsp_valid_s = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops any in-flight transfer silently.
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            state_r   <= ST_IDLE;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_r     <= '0;
            psel      <= '0;
            penable   <= 1'b0;
            paddr     <= '0;
            pwrite    <= 1'b0;
            pwdata    <= '0;
            pstrb     <= '0;
            pprot     <= 3'b000;
        end else begin
            state_r   <= state_s;
            req_ready <= req_ready_s;
            rsp_valid <= rsp_valid_s;
            rsp_r     <= rsp_s;
            psel      <= psel_s;
            penable   <= penable_s;
            paddr     <= paddr_s;
            pwrite    <= pwrite_s;
            pwdata    <= pwdata_s;
            pstrb     <= pstrb_s;
            pprot     <= pprot_s;
        end
    end

endmodule

// File: doc/apb_requester.md
APB_REQUESTER -- requirements
Module: apb_requester

Interface
REQ-001 SHALL have parameter VERSION, 2, APB protocol generation (2..5).
REQ-002 SHALL have parameter PSEL_WIDTH, 1, number of completers, one psel bit each.
REQ-003 SHALL have parameter ADDR_WIDTH, 32, paddr width.
REQ-004 SHALL have parameter DATA_WIDTH, 32, pwdata/prdata width (8, 16 or 32); PSTRB_WIDTH = DATA_WIDTH/8.
REQ-005 SHALL have parameter Pstrb_Support, 0, pstrb driven (effective only when VERSION>=4).
REQ-006 SHALL have parameter Protection_Support, 0, pprot driven (effective only when VERSION>=4).
REQ-007 SHALL have parameter TIMEOUT_CYCLES, 0, maximum ACCESS cycles before abort; 0 disables the timeout.
REQ-008 SHALL have ports: pclk in 1 clock; presetn in 1, the single clock, with synchronous active-low reset.
REQ-009 SHALL have ports: req_valid in 1; req_ready out 1; req_write in 1; req_addr in ADDR_WIDTH; req_wdata in DATA_WIDTH; req_strb in PSTRB_WIDTH; req_prot in 3; req_sel in SELW, where SELW = max(1, clog2(PSEL_WIDTH)) and req_sel is the completer index.
REQ-010 SHALL have ports: rsp_valid out 1; rsp_ready in 1; rsp_rdata out DATA_WIDTH; rsp_err out 1; rsp_timeout out 1.
REQ-011 SHALL have ports: paddr out ADDR_WIDTH; psel out PSEL_WIDTH; penable out 1; pwrite out 1; pwdata out DATA_WIDTH; pstrb out PSTRB_WIDTH; pprot out 3; pready in 1; prdata in DATA_WIDTH; pslverr in 1.

Function
REQ-012 SHALL implement FSM states IDLE, SETUP, ACCESS, RESP.
REQ-013 SHALL drive req_ready=1 only in IDLE; req_valid&&req_ready captures all req_* fields and moves the FSM to SETUP.
REQ-014 SHALL, in SETUP, assert psel[req_sel] one-hot with penable=0, drive the captured paddr/pwrite/pwdata/pstrb/pprot, and move unconditionally to ACCESS.
REQ-015 SHALL, in ACCESS, assert penable=1 and hold all APB outputs stable until completion.
REQ-016 SHALL complete on a pclk edge in ACCESS with pready=1, capturing prdata (reads only; 0 for writes) and pslverr into rsp_rdata/rsp_err, deasserting psel/penable, and moving to RESP.
REQ-017 SHALL treat pready as 1 and pslverr as 0 when VERSION<3 (fixed 2-cycle transfer).
REQ-018 SHALL drive pstrb=req_strb for writes, all-zero for reads, and constant zero when Pstrb_Support=0 or VERSION<4.
REQ-019 SHALL drive pprot=req_prot when Protection_Support=1 and VERSION>=4, otherwise constant zero.
REQ-020 SHALL drive paddr, pwrite, pwdata, pstrb and pprot to zero while psel is all-zero.
REQ-021 SHALL ignore req_sel values >= PSEL_WIDTH by completing with no psel asserted, rsp_err=1 and rsp_timeout=0, via SETUP and ACCESS without waiting for pready.
REQ-022 SHALL count ACCESS cycles; when TIMEOUT_CYCLES>0 and the count reaches TIMEOUT_CYCLES with pready=0, SHALL abort: psel/penable to 0, rsp_err=1, rsp_timeout=1, rsp_rdata=0, then go to RESP.
REQ-023 SHALL complete normally, with no timeout, when pready=1 arrives in the same cycle the count reaches TIMEOUT_CYCLES.
REQ-024 SHALL hold rsp_valid=1 with stable rsp_* in RESP until rsp_ready=1, then return to IDLE; minimum turnaround is 4 cycles, with req_ready=1 again on the cycle after the handshake.
REQ-025 SHALL size the timeout counter as clog2(TIMEOUT_CYCLES+1) bits, saturating and never wrapping.

Reset
REQ-026 SHALL, on any pclk edge with presetn=0 (including mid-transfer), return to IDLE, drop any pending transfer without issuing a response, and clear the timeout counter.
REQ-027 SHALL reset all outputs to zero except req_ready, which is 1 after reset deasserts.

Structure
REQ-028 SHALL place the FSM state enum and the response struct (rdata, err, timeout) in shared package apb_pkg.
REQ-029 SHALL place the timeout counter in sub-module apb_timeout_counter (inputs: enable, clear, limit; output: expired).

Verification
REQ-030 SHALL test: VERSION=2, write addr 0x10 data 0xA5A5A5A5 -> psel rises on cycle 1, penable on cycle 2, rsp_valid on cycle 3, rsp_err=0.
REQ-031 SHALL test: VERSION=3, read, pready low for 3 ACCESS cycles, prdata=0x1234 -> rsp_rdata=0x1234, all APB outputs stable throughout the wait.
REQ-032 SHALL test: VERSION=4, Pstrb_Support=1, write req_strb=0b0101 -> pstrb=0b0101; a subsequent read -> pstrb=0.
REQ-033 SHALL test: TIMEOUT_CYCLES=8, pready held 0 -> abort after 8 ACCESS cycles with rsp_err=1 and rsp_timeout=1; pready=1 on cycle 8 -> normal completion.
REQ-034 SHALL test: PSEL_WIDTH=4, req_sel=2 -> psel=0b0100; PSEL_WIDTH=3, req_sel=3 -> rsp_err=1 with psel never asserted.
REQ-035 SHALL test: presetn=0 during ACCESS -> next edge psel=0, penable=0, req_ready=0, no rsp_valid ever issued.
